// File: rtl/biquad8_coeff_loader.sv
// Coefficient table and load sequencer for the biquad8 filter: streams the table
// into the cascaded DSP B1 registers (highest entry first), then pulses update.
module biquad8_coeff_loader #(
  parameter int NCOEFF   = 2,
  parameter int ADR_BITS = 1,
  parameter int CBITS    = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADR_BITS-1:0] cfg_adr_i,
  input  logic [CBITS-1:0]    cfg_dat_i,
  input  logic                cfg_wr_i,
  output logic [CBITS-1:0]    cfg_dat_o,
  input  logic                load_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CBITS-1:0]    coeff_dat_o,
  output logic                coeff_wr_o,
  output logic                coeff_update_o
);

  typedef enum logic [2:0] {IDLE, WR, HOLD, UPD, DONE} state_t;

  localparam logic [ADR_BITS-1:0] LAST_IDX = ADR_BITS'(NCOEFF - 1);

  state_t              state_r, state_s;
  logic [ADR_BITS-1:0] idx_r, idx_s;
  logic                pend_r, pend_s;
  logic [CBITS-1:0]    tbl_r [NCOEFF];
  logic [CBITS-1:0]    rd_s, word_s;
  logic [CBITS-1:0]    cfg_dat_r, coeff_dat_r;
  logic                coeff_wr_r, coeff_update_r, busy_r, done_r;

  // Next-state, word index and pending-reload flag
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    pend_s  = pend_r;
    case (state_r)
      IDLE: begin
        if (load_i) begin
          state_s = WR;
          idx_s   = LAST_IDX;
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        state_s = HOLD;
        pend_s  = pend_r | load_i;
      end
      HOLD: begin
        pend_s = pend_r | load_i;
        if (idx_r != ADR_BITS'(0)) begin
          state_s = WR;
          idx_s   = idx_r - ADR_BITS'(1);
        end else begin
          state_s = UPD;
        end
      end
      UPD: begin
        state_s = DONE;
        pend_s  = pend_r | load_i;
      end
      DONE: begin
        pend_s = 1'b0;
        if (load_i || pend_r) begin
          state_s = WR;
          idx_s   = LAST_IDX;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
        pend_s  = 1'b0;
      end
    endcase
  end

  // Table muxes built as AND-OR so out-of-range addresses simply read 0
  always_comb begin
    rd_s   = '0;
    word_s = '0;
    for (int i = 0; i < NCOEFF; i++) begin
      rd_s   = rd_s   | ({CBITS{cfg_adr_i == ADR_BITS'(i)}} & tbl_r[i]);
      word_s = word_s | ({CBITS{idx_s == ADR_BITS'(i)}} & tbl_r[i]);
    end
  end

  // Coefficient table; writes to addresses >= NCOEFF match no entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEFF; i++) tbl_r[i] <= '0;
    end else begin
      for (int i = 0; i < NCOEFF; i++) begin
        if (cfg_wr_i && (cfg_adr_i == ADR_BITS'(i))) tbl_r[i] <= cfg_dat_i;
      end
    end
  end

  // FSM state and output registers, all loaded from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      idx_r          <= '0;
      pend_r         <= 1'b0;
      cfg_dat_r      <= '0;
      coeff_dat_r    <= '0;
      coeff_wr_r     <= 1'b0;
      coeff_update_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      pend_r         <= pend_s;
      cfg_dat_r      <= rd_s;
      coeff_wr_r     <= (state_s == WR);
      coeff_update_r <= (state_s == UPD);
      busy_r         <= (state_s == WR) || (state_s == HOLD) || (state_s == UPD);
      done_r         <= (state_s == DONE);
      // word is latched on entry to WR, before any same-edge table write lands
      if (state_s == WR) coeff_dat_r <= word_s;
    end
  end

  assign cfg_dat_o      = cfg_dat_r;
  assign coeff_dat_o    = coeff_dat_r;
  assign coeff_wr_o     = coeff_wr_r;
  assign coeff_update_o = coeff_update_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench: expected outputs are queued per cycle when stimulus is driven
// and compared at the falling edge when that cycle is reached.
module tb_biquad8_coeff_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  cfg_adr;
  logic [17:0] cfg_dat;
  logic        cfg_wr;
  logic        load;
  logic        load1;
  logic [17:0] rd0, rd1, cdat0, cdat1;
  logic        busy0, done0, wr0, upd0;
  logic        busy1, done1, wr1, upd1;

  int n_checks = 0;
  int n_errors = 0;
  int cnt = 0;
  bit fin = 1'b0;

  typedef struct {
    int          cyc;
    bit          rd;
    bit          d1;
    logic [17:0] rdv;
    logic [17:0] dat;
    logic        wr, upd, busy, done;
  } exp_t;
  exp_t exp_q[$];

  biquad8_coeff_loader #(.NCOEFF(2), .ADR_BITS(1), .CBITS(18)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_adr_i(cfg_adr), .cfg_dat_i(cfg_dat),
    .cfg_wr_i(cfg_wr), .cfg_dat_o(rd0), .load_i(load), .busy_o(busy0),
    .done_o(done0), .coeff_dat_o(cdat0), .coeff_wr_o(wr0), .coeff_update_o(upd0)
  );

  biquad8_coeff_loader #(.NCOEFF(1), .ADR_BITS(1), .CBITS(18)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_adr_i(cfg_adr), .cfg_dat_i(cfg_dat),
    .cfg_wr_i(cfg_wr), .cfg_dat_o(rd1), .load_i(load1), .busy_o(busy1),
    .done_o(done1), .coeff_dat_o(cdat1), .coeff_wr_o(wr1), .coeff_update_o(upd1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cnt, obs, exp_v);
    end
  endtask

  task automatic push_out(input int c, input logic [17:0] d, input logic w, input logic u,
                          input logic b, input logic dn);
    exp_t e;
    e.cyc = c; e.rd = 1'b0; e.d1 = 1'b0; e.rdv = 18'd0;
    e.dat = d; e.wr = w; e.upd = u; e.busy = b; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input int c, input bit which, input logic [17:0] v);
    exp_t e;
    e.cyc = c; e.rd = 1'b1; e.d1 = which; e.rdv = v;
    e.dat = 18'd0; e.wr = 1'b0; e.upd = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    exp_q.push_back(e);
  endtask

  // One load sequence whose load_i is sampled at the edge ending cycle `base`
  task automatic push_seq(input int base, input logic [17:0] hi, input logic [17:0] lo);
    for (int k = 1; k <= 6; k++)
      push_out(base + k, (k <= 2) ? hi : lo, (k == 1) || (k == 3), k == 5, k <= 5, k == 6);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("wr_upd_exclusive", {31'd0, wr0 & upd0}, 32'd0);
    while (exp_q.size() != 0 && exp_q[0].cyc <= cnt) begin
      e = exp_q.pop_front();
      if (e.cyc != cnt) begin
        chk("schedule", 32'(cnt), 32'(e.cyc));
      end else if (e.rd) begin
        if (e.d1) chk("cfg_dat_o(ncoeff1)", 32'(rd1), 32'(e.rdv));
        else      chk("cfg_dat_o", 32'(rd0), 32'(e.rdv));
      end else begin
        chk("coeff_dat_o", 32'(cdat0), 32'(e.dat));
        chk("coeff_wr_o", 32'(wr0), 32'(e.wr));
        chk("coeff_update_o", 32'(upd0), 32'(e.upd));
        chk("busy_o", 32'(busy0), 32'(e.busy));
        chk("done_o", 32'(done0), 32'(e.done));
      end
    end
    if (fin) begin
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n = 1'b0; cfg_adr = 1'b0; cfg_dat = 18'd0; cfg_wr = 1'b0; load = 1'b0; load1 = 1'b0;
    step(2);
    // reset state, sampled while rst_n is still low
    push_out(cnt, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_rd(cnt, 1'b0, 18'd0);
    push_rd(cnt, 1'b1, 18'd0);
    step(1);
    rst_n = 1'b1; cfg_adr = 1'b1;
    push_rd(cnt + 1, 1'b0, 18'd0);
    push_out(cnt + 1, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // table write and readback
    cfg_wr = 1'b1; cfg_adr = 1'b0; cfg_dat = 18'h00123;
    step(1);
    cfg_adr = 1'b1; cfg_dat = 18'h3FFFF;
    step(1);
    cfg_wr = 1'b0; cfg_adr = 1'b0;
    push_rd(cnt + 1, 1'b0, 18'h00123);
    push_rd(cnt + 1, 1'b1, 18'h00123);
    step(1);
    cfg_adr = 1'b1;
    push_rd(cnt + 1, 1'b0, 18'h3FFFF);
    push_rd(cnt + 1, 1'b1, 18'd0);
    step(1);

    // basic load sequence
    e0 = cnt;
    load = 1'b1;
    push_seq(e0, 18'h3FFFF, 18'h00123);
    push_out(e0 + 7, 18'h00123, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    load = 1'b0;
    step(7);

    // loads at cycles 2 and 3 collapse into one re-run
    e0 = cnt;
    load = 1'b1;
    push_seq(e0, 18'h3FFFF, 18'h00123);
    push_seq(e0 + 6, 18'h3FFFF, 18'h00123);
    push_out(e0 + 13, 18'h00123, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    load = 1'b0;
    step(1);
    load = 1'b1;
    step(2);
    load = 1'b0;
    step(11);

    // table write in the same cycle as load: old word is streamed
    e0 = cnt;
    load = 1'b1; cfg_wr = 1'b1; cfg_adr = 1'b1; cfg_dat = 18'h00055;
    push_seq(e0, 18'h3FFFF, 18'h00123);
    step(1);
    load = 1'b0; cfg_wr = 1'b0;
    step(7);
    e0 = cnt;
    load = 1'b1;
    push_seq(e0, 18'h00055, 18'h00123);
    push_rd(e0 + 7, 1'b0, 18'h00055);
    push_rd(e0 + 7, 1'b1, 18'd0);
    step(1);
    load = 1'b0;
    step(7);

    // reset at cycle 3 of a sequence aborts it without an update pulse
    e0 = cnt;
    load = 1'b1;
    push_out(e0 + 1, 18'h00055, 1'b1, 1'b0, 1'b1, 1'b0);
    push_out(e0 + 2, 18'h00055, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    load = 1'b0;
    step(2);
    rst_n = 1'b0;
    push_out(e0 + 3, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_out(e0 + 4, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1; cfg_adr = 1'b0;
    push_out(e0 + 5, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_rd(e0 + 5, 1'b0, 18'd0);
    step(1);
    cfg_adr = 1'b1;
    push_out(e0 + 6, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_rd(e0 + 6, 1'b0, 18'd0);
    step(1);

    // normal operation after reset with fresh coefficients
    cfg_wr = 1'b1; cfg_adr = 1'b0; cfg_dat = 18'h00AAA;
    step(1);
    cfg_adr = 1'b1; cfg_dat = 18'h15555;
    step(1);
    cfg_wr = 1'b0;
    e0 = cnt;
    load = 1'b1;
    push_seq(e0, 18'h15555, 18'h00AAA);
    push_out(e0 + 7, 18'h00AAA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    load = 1'b0;
    step(8);
    fin = 1'b1;
  end

endmodule
